// File: rtl/step_det_pkg.sv
// Shared types and default tuning constants for the step detector.
package step_det_pkg;

  typedef enum logic [1:0] {
    ST_BELOW    = 2'd0,
    ST_ABOVE    = 2'd1,
    ST_HOLDOFF  = 2'd2,
    ST_WAIT_LOW = 2'd3
  } state_e;

  localparam logic signed [15:0] DEF_THR_HI    = 16'sd2000;
  localparam logic signed [15:0] DEF_THR_LO    = 16'sd500;
  localparam int                 DEF_HOLDOFF   = 8;
  localparam int                 DEF_MAX_WIDTH = 64;
  localparam int                 DEF_CNT_W     = 16;

  // Bits needed to hold values 0..max_val; never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Count up on inc, stick at all-ones, drop to zero on clr or rst.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/step_detector.sv
// Hysteresis step detector with width abort and post-step holdoff.
module step_detector
  import step_det_pkg::*;
#(
  parameter logic signed [15:0] THR_HI    = DEF_THR_HI,
  parameter logic signed [15:0] THR_LO    = DEF_THR_LO,
  parameter int                 HOLDOFF   = DEF_HOLDOFF,
  parameter int                 MAX_WIDTH = DEF_MAX_WIDTH,
  parameter int                 CNT_W     = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_valid,
  input  logic signed [15:0]      data_in,
  input  logic                    clr_count,
  output logic                    step_pulse,
  output logic [CNT_W-1:0]        step_count,
  output logic signed [15:0]      peak_value,
  output logic                    abort_pulse
);

  localparam int WID_W = cnt_width(MAX_WIDTH);
  localparam int HO_W  = cnt_width(HOLDOFF);

  state_e                state, state_nxt;
  logic signed [15:0]    peak_run, peak_nxt;
  logic [WID_W-1:0]      width_cnt, width_nxt;
  logic [HO_W-1:0]       holdoff_cnt, holdoff_nxt;
  logic                  step_evt;
  logic                  abort_evt;

  // Next-state and datapath decisions; nothing moves without sample_valid.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_nxt   = state;
    peak_nxt    = peak_run;
    width_nxt   = width_cnt;
    holdoff_nxt = holdoff_cnt;
    step_evt    = 1'b0;
    abort_evt   = 1'b0;
    if (sample_valid) begin
      unique case (state)
        ST_BELOW: begin
          if (data_in > THR_HI) begin
            state_nxt = ST_ABOVE;
            peak_nxt  = data_in;
            width_nxt = WID_W'(1);
          end
        end
        ST_ABOVE: begin
          if (data_in > peak_run) peak_nxt = data_in;
          if (data_in < THR_LO) begin
            // Completion beats abort when both happen on the same sample.
            step_evt  = 1'b1;
            width_nxt = width_cnt + 1'b1;
            if (HOLDOFF == 0) begin
              state_nxt = ST_BELOW;
            end else begin
              state_nxt   = ST_HOLDOFF;
              holdoff_nxt = HO_W'(HOLDOFF);
            end
          end else if (width_cnt >= WID_W'(MAX_WIDTH)) begin
            abort_evt = 1'b1;
            state_nxt = ST_WAIT_LOW;
          end else begin
            width_nxt = width_cnt + 1'b1;
          end
        end
        ST_HOLDOFF: begin
          holdoff_nxt = holdoff_cnt - 1'b1;
          if (holdoff_cnt <= HO_W'(1)) begin
            holdoff_nxt = '0;
            state_nxt   = ST_BELOW;
          end
        end
        ST_WAIT_LOW: begin
          if (data_in < THR_LO) state_nxt = ST_BELOW;
        end
        default: state_nxt = ST_BELOW;
      endcase
    end
  end

  // State, tracking registers and registered pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_BELOW;
      peak_run    <= '0;
      width_cnt   <= '0;
      holdoff_cnt <= '0;
      step_pulse  <= 1'b0;
      abort_pulse <= 1'b0;
      peak_value  <= '0;
    end else begin
      state       <= state_nxt;
      peak_run    <= peak_nxt;
      width_cnt   <= width_nxt;
      holdoff_cnt <= holdoff_nxt;
      step_pulse  <= step_evt;
      abort_pulse <= abort_evt;
      if (step_evt) peak_value <= peak_run;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_step_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (step_evt),
    .clr   (clr_count),
    .count (step_count)
  );

endmodule

// File: tb/tb_step_detector.sv
// Scenario bench for step_detector: expectations queued per sample, checked one cycle later.
module tb_step_detector;

  localparam int CNT_W   = 4;
  localparam int HOLDOFF = 8;

  typedef struct {
    logic                step;
    logic                abort;
    logic [CNT_W-1:0]    count;
    logic signed [15:0]  peak;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                sample_valid = 1'b0;
  logic signed [15:0]  data_in = '0;
  logic                clr_count = 1'b0;
  logic                step_pulse;
  logic [CNT_W-1:0]    step_count;
  logic signed [15:0]  peak_value;
  logic                abort_pulse;

  int errors = 0;
  int checks = 0;

  exp_t               sb[$];
  exp_t               got;
  logic [CNT_W-1:0]   exp_count = '0;
  logic signed [15:0] exp_peak = '0;
  logic               fire = 1'b0;
  logic               mon_en = 1'b0;

  always #5 clk = ~clk;

  step_detector #(
    .CNT_W(CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .data_in      (data_in),
    .clr_count    (clr_count),
    .step_pulse   (step_pulse),
    .step_count   (step_count),
    .peak_value   (peak_value),
    .abort_pulse  (abort_pulse)
  );

  // Remember which edges consumed a valid sample.
  always @(posedge clk) fire <= sample_valid & ~rst;

  // Scoreboard: compare outputs one cycle after each sample; pulses must be idle otherwise.
  always @(negedge clk) begin
    if (mon_en) begin
      if (fire) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: output cycle with no queued expectation");
        end else begin
          got = sb.pop_front();
          if (step_pulse !== got.step) begin
            errors++;
            $display("FAIL step_pulse @%0t: got %b want %b", $time, step_pulse, got.step);
          end
          checks++;
          if (abort_pulse !== got.abort) begin
            errors++;
            $display("FAIL abort_pulse @%0t: got %b want %b", $time, abort_pulse, got.abort);
          end
          checks++;
          if (step_count !== got.count) begin
            errors++;
            $display("FAIL step_count @%0t: got %0d want %0d", $time, step_count, got.count);
          end
          checks++;
          if (peak_value !== got.peak) begin
            errors++;
            $display("FAIL peak_value @%0t: got %0d want %0d", $time, peak_value, got.peak);
          end
        end
      end else begin
        checks++;
        if ((step_pulse !== 1'b0) || (abort_pulse !== 1'b0)) begin
          errors++;
          $display("FAIL idle_pulses @%0t: got step=%b abort=%b want 0/0",
                   $time, step_pulse, abort_pulse);
        end
      end
    end
  end

  // Drive one valid sample and queue what the outputs must show one cycle later.
  task automatic send(input logic signed [15:0] d, input logic clr, input logic st,
                      input logic ab, input logic signed [15:0] pk);
    exp_t e;
    if (st) begin
      if (clr) exp_count = '0;
      else if (exp_count != '1) exp_count = exp_count + 1'b1;
      exp_peak = pk;
    end else if (clr) begin
      exp_count = '0;
    end
    e.step  = st;
    e.abort = ab;
    e.count = exp_count;
    e.peak  = exp_peak;
    sb.push_back(e);
    @(negedge clk);
    data_in      = d;
    sample_valid = 1'b1;
    clr_count    = clr;
    @(negedge clk);
    sample_valid = 1'b0;
    clr_count    = 1'b0;
  endtask

  // Samples swallowed by the post-step holdoff.
  task automatic ignore_holdoff();
    repeat (HOLDOFF) send(16'sd0, 1'b0, 1'b0, 1'b0, 16'sd0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (step_pulse !== 1'b0) begin
      errors++; $display("FAIL reset_step_pulse: got %b want 0", step_pulse);
    end
    checks++;
    if (abort_pulse !== 1'b0) begin
      errors++; $display("FAIL reset_abort_pulse: got %b want 0", abort_pulse);
    end
    checks++;
    if (step_count !== '0) begin
      errors++; $display("FAIL reset_step_count: got %0d want 0", step_count);
    end
    checks++;
    if (peak_value !== 16'sd0) begin
      errors++; $display("FAIL reset_peak_value: got %0d want 0", peak_value);
    end
    rst    = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_basic_step();
    send(16'sd0,    1'b0, 1'b0, 1'b0, 16'sd0);
    send(16'sd2500, 1'b0, 1'b0, 1'b0, 16'sd0);
    send(16'sd3000, 1'b0, 1'b0, 1'b0, 16'sd0);
    send(16'sd2800, 1'b0, 1'b0, 1'b0, 16'sd0);
    send(16'sd400,  1'b0, 1'b1, 1'b0, 16'sd3000);
    checks++;
    if (step_count !== 4'd1) begin
      errors++; $display("FAIL basic_count: got %0d want 1", step_count);
    end
    ignore_holdoff();
  endtask

  task automatic test_hysteresis();
    send(16'sd2000, 1'b0, 1'b0, 1'b0, 16'sd0);  // equal to THR_HI: must not arm
    send(16'sd400,  1'b0, 1'b0, 1'b0, 16'sd0);  // would complete a step if armed
    send(16'sd2001, 1'b0, 1'b0, 1'b0, 16'sd0);
    send(16'sd500,  1'b0, 1'b0, 1'b0, 16'sd0);  // equal to THR_LO: stays ABOVE
    send(16'sd499,  1'b0, 1'b1, 1'b0, 16'sd2001);
    ignore_holdoff();
  endtask

  task automatic test_width_abort();
    repeat (64) send(16'sd2500, 1'b0, 1'b0, 1'b0, 16'sd0);
    send(16'sd2500, 1'b0, 1'b0, 1'b1, 16'sd0);
    send(16'sd400,  1'b0, 1'b0, 1'b0, 16'sd0);
    checks++;
    if (peak_value !== 16'sd2001) begin
      errors++; $display("FAIL abort_peak_kept: got %0d want 2001", peak_value);
    end
    // Back in BELOW (not holdoff): a fresh excursion completes at once.
    send(16'sd2500, 1'b0, 1'b0, 1'b0, 16'sd0);
    send(16'sd400,  1'b0, 1'b1, 1'b0, 16'sd2500);
    ignore_holdoff();
  endtask

  task automatic test_holdoff();
    send(16'sd2600, 1'b0, 1'b0, 1'b0, 16'sd0);
    send(16'sd100,  1'b0, 1'b1, 1'b0, 16'sd2600);
    send(16'sd2500, 1'b0, 1'b0, 1'b0, 16'sd0);
    send(16'sd100,  1'b0, 1'b0, 1'b0, 16'sd0);
    repeat (HOLDOFF - 2) send(16'sd0, 1'b0, 1'b0, 1'b0, 16'sd0);
    send(16'sd2500, 1'b0, 1'b0, 1'b0, 16'sd0);
    send(16'sd100,  1'b0, 1'b1, 1'b0, 16'sd2500);
    checks++;
    if (step_count !== 4'd5) begin
      errors++; $display("FAIL holdoff_count: got %0d want 5", step_count);
    end
    ignore_holdoff();
  endtask

  task automatic test_saturation_clear();
    for (int i = 0; i < 12; i++) begin
      send(16'sd2500 + 16'(i), 1'b0, 1'b0, 1'b0, 16'sd0);
      send(16'sd400, 1'b0, 1'b1, 1'b0, 16'sd2500 + 16'(i));
      ignore_holdoff();
    end
    checks++;
    if (step_count !== 4'd15) begin
      errors++; $display("FAIL saturate_count: got %0d want 15", step_count);
    end
    send(16'sd2700, 1'b0, 1'b0, 1'b0, 16'sd0);
    send(16'sd400,  1'b1, 1'b1, 1'b0, 16'sd2700);
    checks++;
    if (step_count !== 4'd0) begin
      errors++; $display("FAIL clear_with_step: got %0d want 0", step_count);
    end
    ignore_holdoff();
  endtask

  task automatic test_reset_mid_excursion();
    send(16'sd2500, 1'b0, 1'b0, 1'b0, 16'sd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_count = '0;
    exp_peak  = 16'sd0;
    send(16'sd400, 1'b0, 1'b0, 1'b0, 16'sd0);
    checks++;
    if (step_count !== 4'd0) begin
      errors++; $display("FAIL midreset_count: got %0d want 0", step_count);
    end
    checks++;
    if (peak_value !== 16'sd0) begin
      errors++; $display("FAIL midreset_peak: got %0d want 0", peak_value);
    end
  endtask

  initial begin
    test_reset();
    test_basic_step();
    test_hysteresis();
    test_width_abort();
    test_holdoff();
    test_saturation_clear();
    test_reset_mid_excursion();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/step_detector.md
STEP_DETECTOR -- requirements
Module: step_detector

Interface
REQ-001 Parameter THR_HI, 16'sd2000, signed rising threshold; a sample strictly greater than this arms a step.
REQ-002 Parameter THR_LO, 16'sd500, signed falling threshold; a sample strictly less than this completes a step. THR_LO < THR_HI is required.
REQ-003 Parameter HOLDOFF, 8, number of valid samples ignored after a step (0 allowed).
REQ-004 Parameter MAX_WIDTH, 64, maximum valid samples tolerated in ABOVE before abort (at least 1).
REQ-005 Parameter CNT_W, 16, width of step_count.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 sample_valid  input  1  one-cycle strobe; a new filtered sample is present on data_in.
REQ-009 data_in  input  16  signed filtered sample from the upstream moving-average stage.
REQ-010 clr_count  input  1  synchronous clear of step_count.
REQ-011 step_pulse  output  1  one-cycle pulse per detected step.
REQ-012 step_count  output  CNT_W  unsigned saturating step total.
REQ-013 peak_value  output  16  signed maximum sample of the last completed step.
REQ-014 abort_pulse  output  1  one-cycle pulse when an excursion exceeds MAX_WIDTH.

Function
REQ-015 The block SHALL evaluate data_in only in cycles with sample_valid=1; otherwise all state, counters and peak tracking SHALL hold.
REQ-016 FSM states SHALL be BELOW, ABOVE, HOLDOFF and WAIT_LOW.
REQ-017 BELOW: a valid sample > THR_HI SHALL move the FSM to ABOVE, load peak_run with the sample and load width_cnt with 1.
REQ-018 ABOVE: every valid sample SHALL update peak_run to max(peak_run, sample) as a signed compare, and SHALL increment width_cnt.
REQ-019 ABOVE: a valid sample < THR_LO SHALL complete a step: step_pulse=1 in the next cycle, step_count+1, peak_value<=peak_run, and FSM to HOLDOFF with holdoff_cnt=HOLDOFF. If HOLDOFF=0, the FSM goes to BELOW instead.
REQ-020 ABOVE: if a valid sample arrives with width_cnt=MAX_WIDTH and no completion, the block SHALL pulse abort_pulse for one cycle, leave step_count and peak_value unchanged, and move to WAIT_LOW. Completion takes priority over abort on the same sample.
REQ-021 WAIT_LOW: a valid sample < THR_LO SHALL move the FSM to BELOW with no step.
REQ-022 HOLDOFF: each valid sample SHALL decrement holdoff_cnt and is otherwise ignored. On the sample that brings the count to 0, the FSM moves to BELOW; the next valid sample is evaluated in BELOW.
REQ-023 Output latency SHALL be one clk cycle: step_pulse, abort_pulse, step_count and peak_value become visible in the cycle after the edge that samples the deciding sample_valid.
REQ-024 step_count SHALL saturate at 2^CNT_W-1. Further steps still pulse step_pulse.
REQ-025 If clr_count and a step coincide, step_count SHALL become 0 and step_pulse SHALL still assert.
REQ-026 Comparisons SHALL be signed 16-bit. Equality with either threshold SHALL NOT cause a transition.

Reset
REQ-027 When rst=1 at an edge, the block SHALL set FSM=BELOW, step_pulse=0, abort_pulse=0, step_count=0, peak_value=0, peak_run=0, width_cnt=0 and holdoff_cnt=0. rst overrides sample_valid and clr_count.
REQ-028 Reset during ABOVE, HOLDOFF or WAIT_LOW SHALL discard the excursion in progress; no step or abort is emitted.

Structure
REQ-029 The package step_det_pkg SHALL hold the FSM state enum and the default threshold, HOLDOFF and MAX_WIDTH constants.
REQ-030 The saturating counter with clear SHALL be the sub-module sat_counter (parameter W; inputs inc, clr).
REQ-031 width_cnt and holdoff_cnt widths SHALL be derived via clog2 from MAX_WIDTH and HOLDOFF.

Verification (defaults unless stated; every sample accompanied by a one-cycle sample_valid)
REQ-032 Samples 0, 2500, 3000, 2800, 400 -> exactly one step_pulse, one cycle after the 400 sample; step_count=1; peak_value=3000.
REQ-033 Hysteresis: samples 2000 -> no transition; then 2001, then 500 -> still ABOVE; then 499 -> one step_pulse.
REQ-034 Holdoff: after a step, samples 2500, 100 within the next 8 samples -> no step. The 9th post-step sample 2500, followed by 100 -> step_count=2.
REQ-035 Width abort: 65 consecutive samples of 2500 -> one abort_pulse on the 65th sample and step_count unchanged. Then 400 -> no step_pulse, FSM BELOW.
REQ-036 Saturation and clear with CNT_W=4: 16 steps -> step_count=15. Then clr_count coinciding with a completing sample -> step_count=0 and step_pulse=1.
REQ-037 Reset mid-excursion: 2500, rst for one cycle, then 400 -> no step_pulse; step_count=0; peak_value=0.
